fpadd_arb: RTL and testbench

FPADD_ARB -- requirements
Module: fpadd_arb

---
 rtl/fpadd_arb_pkg.sv | 21 ++
 rtl/fpadd_arb_core.sv | 72 +++++++
 rtl/fpadd_arb.sv | 81 ++++++++
 tb/tb_fpadd_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_arb_pkg.sv
// Shared constants for the two-requester FP adder arbiter: state encoding, data width
// and a leading-zero counter used by the adder datapath.
package fpadd_arb_pkg;

  localparam int unsigned FP_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  // Leading zeros of a 27-bit value; returns 27 for an all-zero input.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

endpackage

// File: rtl/fpadd_arb_core.sv
// Single-precision adder (round-to-nearest-even, gradual underflow, canonical NaN)
// with a result register loaded when load is high; latency 1.
module fp_add_core
  import fpadd_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [FP_W-1:0] opa,
  input  logic [FP_W-1:0] opb,
  output logic [FP_W-1:0] sum
);

  logic        swap, rnd, nan_a, nan_b, inf_a, inf_b;
  logic [31:0] big, sml, sum_d;
  logic [7:0]  eb, es, d;
  logic [23:0] mb, ms;
  logic [4:0]  dd, lz, sh;
  logic [26:0] xs, mask, al, n;
  logic [27:0] s;
  logic [8:0]  e, e_n;
  logic [30:0] mag;

  always_comb begin
    swap = opb[30:0] > opa[30:0];
    big  = swap ? opb : opa;
    sml  = swap ? opa : opb;
    // Denormals use exponent 1 with no hidden bit.
    eb   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb   = {big[30:23] != 8'd0, big[22:0]};
    ms   = {sml[30:23] != 8'd0, sml[22:0]};
    d    = eb - es;
    dd   = (d > 8'd27) ? 5'd27 : d[4:0];
    xs   = {ms, 3'b000};
    mask = (27'd1 << dd) - 27'd1;
    al   = (xs >> dd) | {26'd0, |(xs & mask)};
    if (big[31] == sml[31]) s = {1'b0, mb, 3'b000} + {1'b0, al};
    else                    s = {1'b0, mb, 3'b000} - {1'b0, al};
    e  = {1'b0, eb};
    lz = lzc27(s[26:0]);
    sh = 5'd0;
    if (s[27]) begin
      n   = {s[27:2], s[1] | s[0]};
      e_n = e + 9'd1;
    end else begin
      // Stop normalising at exponent 1 so small results come out denormal.
      sh  = ({4'd0, lz} < e) ? lz : (e[4:0] - 5'd1);
      n   = s[26:0] << sh;
      e_n = e - {4'd0, sh};
    end
    rnd   = n[2] & (n[1] | n[0] | n[3]);
    // Rounding carry ripples into the exponent field, including up to infinity.
    mag   = {(n[26] ? e_n[7:0] : 8'd0), n[25:3]} + {30'd0, rnd};
    nan_a = (&opa[30:23]) & (|opa[22:0]);
    nan_b = (&opb[30:23]) & (|opb[22:0]);
    inf_a = (&opa[30:23]) & ~(|opa[22:0]);
    inf_b = (&opb[30:23]) & ~(|opb[22:0]);
    if (nan_a | nan_b | (inf_a & inf_b & (opa[31] != opb[31]))) sum_d = 32'h7FC0_0000;
    else if (inf_a)          sum_d = opa;
    else if (inf_b)          sum_d = opb;
    else if (s == 28'd0)     sum_d = {big[31] & sml[31], 31'd0};
    else if (e_n >= 9'd255)  sum_d = {big[31], 8'hFF, 23'd0};
    else                     sum_d = {big[31], mag};
  end

  always_ff @(posedge clk) begin
    if (rst)       sum <= '0;
    else if (load) sum <= sum_d;
  end

endmodule

// File: rtl/fpadd_arb.sv
// Round-robin arbiter sharing one FP adder between two requesters; the result is held
// for the owning requester until its ready handshake.
module fpadd_arb
  import fpadd_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a0_valid,
  input  logic             a1_valid,
  output logic             a0_ready,
  output logic             a1_ready,
  input  logic [FP_W-1:0]  a0_opa,
  input  logic [FP_W-1:0]  a0_opb,
  input  logic [FP_W-1:0]  a1_opa,
  input  logic [FP_W-1:0]  a1_opb,
  output logic             r0_valid,
  output logic             r1_valid,
  input  logic             r0_ready,
  input  logic             r1_ready,
  output logic [FP_W-1:0]  r_sum,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t          state;
  logic            rr, owner, r_done;
  logic [FP_W-1:0] opa_q, opb_q, core_sum;

  always_comb begin
    a0_ready = ~rst & (state == ST_IDLE) & a0_valid & ~(a1_valid & rr);
    a1_ready = ~rst & (state == ST_IDLE) & a1_valid & (~a0_valid | rr);
    r0_valid = ~rst & (state == ST_HOLD) & ~owner;
    r1_valid = ~rst & (state == ST_HOLD) & owner;
    r_done   = (r0_valid & r0_ready) | (r1_valid & r1_ready);
    busy     = ~rst & (state != ST_IDLE);
    r_sum    = rst ? '0 : core_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr       <= 1'b0;
      owner    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (a0_ready | a1_ready) begin
            owner <= a1_ready;
            rr    <= ~a1_ready;
            opa_q <= a1_ready ? a1_opa : a0_opa;
            opb_q <= a1_ready ? a1_opb : a0_opb;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: state <= ST_HOLD;
        ST_HOLD: begin
          if (r_done) begin
            state    <= ST_IDLE;
            op_count <= op_count + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fp_add_core u_core (
    .clk  (clk),
    .rst  (rst),
    .load (state == ST_EXEC),
    .opa  (opa_q),
    .opb  (opb_q),
    .sum  (core_sum)
  );

endmodule

// File: tb/tb_fpadd_arb.sv
// Bench for fpadd_arb: scoreboard of expected {owner, sum} plus directed timing sequences.
module tb_fpadd_arb;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a0_valid, a1_valid, a0_ready, a1_ready;
  logic [31:0]   a0_opa, a0_opb, a1_opa, a1_opb, r_sum;
  logic          r0_valid, r1_valid, r0_ready, r1_ready, busy;
  logic [CW-1:0] op_count;

  int          checks = 0;
  int          passed = 0;
  int          exp_cnt = 0;
  logic [31:0] exp0, exp1;
  logic [32:0] sb_q[$];
  logic [32:0] ent;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  fpadd_arb #(.CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .a0_valid (a0_valid),
    .a1_valid (a1_valid),
    .a0_ready (a0_ready),
    .a1_ready (a1_ready),
    .a0_opa   (a0_opa),
    .a0_opb   (a0_opb),
    .a1_opa   (a1_opa),
    .a1_opb   (a1_opb),
    .r0_valid (r0_valid),
    .r1_valid (r1_valid),
    .r0_ready (r0_ready),
    .r1_ready (r1_ready),
    .r_sum    (r_sum),
    .busy     (busy),
    .op_count (op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
  endtask

  // Scoreboard: push on accept, pop and compare on result handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      exp_cnt = 0;
    end else begin
      if (a0_valid & a0_ready) sb_q.push_back({1'b0, exp0});
      if (a1_valid & a1_ready) sb_q.push_back({1'b1, exp1});
      if ((r0_valid & r0_ready) | (r1_valid & r1_ready)) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          ent = sb_q.pop_front();
          chk("sb_owner", {30'd0, r1_valid, r0_valid}, ent[32] ? 32'd2 : 32'd1);
          chk("sb_sum", r_sum, ent[31:0]);
        end
        exp_cnt++;
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic do_op(input logic req, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want);
    logic acc, done;
    acc  = 1'b0;
    done = 1'b0;
    if (req) begin a1_opa = a; a1_opb = b; exp1 = want; a1_valid = 1'b1; end
    else     begin a0_opa = a; a0_opb = b; exp0 = want; a0_valid = 1'b1; end
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = req ? a1_ready : a0_ready;
      next_cyc();
    end
    a0_valid = 1'b0;
    a1_valid = 1'b0;
    chk("accept_timeout", 32'(acc), 32'd1);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = ~busy;
    end
    chk("drain_timeout", 32'(done), 32'd1);
    next_cyc();
  endtask

  initial begin
    int bad;
    tbl[0]  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    tbl[1]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000};
    tbl[2]  = '{32'h4000_0000, 32'hBF80_0000, 32'h3F80_0000};
    tbl[3]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
    tbl[4]  = '{32'hBFC0_0000, 32'hBFC0_0000, 32'hC040_0000};
    tbl[5]  = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
    tbl[6]  = '{32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001};
    tbl[7]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000};
    tbl[8]  = '{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000};
    tbl[9]  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000};
    tbl[10] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0002};
    tbl[11] = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000};
    tbl[12] = '{32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000};

    rst = 1'b1;
    a0_valid = 1'b1; a1_valid = 1'b1;
    a0_opa = '0; a0_opb = '0; a1_opa = '0; a1_opb = '0;
    exp0 = '0; exp1 = '0;
    r0_ready = 1'b1; r1_ready = 1'b1;

    // Outputs held quiet while in reset, even with requests pending.
    @(negedge clk);
    chk("rst_hs", {27'd0, a0_ready, a1_ready, r0_valid, r1_valid, busy}, 32'd0);
    chk("rst_sum", r_sum, 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    a0_valid = 1'b0; a1_valid = 1'b0;
    next_cyc();
    rst = 1'b0;

    // Single request latency.
    a0_opa = 32'h3F80_0000; a0_opb = 32'h4000_0000; exp0 = 32'h4040_0000; a0_valid = 1'b1;
    @(negedge clk);
    chk("lat_ready", {30'd0, a0_ready, a1_ready}, 32'd2);
    next_cyc();
    a0_valid = 1'b0;
    @(negedge clk);
    chk("lat_exec", {30'd0, busy, r0_valid}, 32'd2);
    next_cyc();
    @(negedge clk);
    chk("lat_hold", {30'd0, r0_valid, r1_valid}, 32'd2);
    next_cyc();
    @(negedge clk);
    chk("lat_idle", 32'(busy), 32'd0);
    chk("lat_count", 32'(op_count), 32'd1);
    next_cyc();

    // Simultaneous requests from reset: a0 first, then a1 although a0 stays valid.
    do_reset();
    a0_opa = 32'h3FC0_0000; a0_opb = 32'h3FC0_0000; exp0 = 32'h4040_0000;
    a1_opa = 32'h4000_0000; a1_opb = 32'hBF80_0000; exp1 = 32'h3F80_0000;
    a0_valid = 1'b1; a1_valid = 1'b1;
    @(negedge clk);
    chk("arb_first", {30'd0, a0_ready, a1_ready}, 32'd2);
    next_cyc();
    @(negedge clk);
    chk("arb_exec_nordy", {30'd0, a0_ready, a1_ready}, 32'd0);
    next_cyc();
    @(negedge clk);
    chk("arb_hold0", {30'd0, r0_valid, r1_valid}, 32'd2);
    next_cyc();
    @(negedge clk);
    chk("arb_second", {30'd0, a0_ready, a1_ready}, 32'd1);
    next_cyc();
    a0_valid = 1'b0; a1_valid = 1'b0;
    repeat (4) next_cyc();
    @(negedge clk);
    chk("arb_count", 32'(op_count), 32'd2);
    next_cyc();

    // Backpressure on requester 1 with a0 waiting.
    r1_ready = 1'b0;
    a1_opa = 32'h4000_0000; a1_opb = 32'hBF80_0000; exp1 = 32'h3F80_0000; a1_valid = 1'b1;
    @(negedge clk);
    chk("bp_accept", 32'(a1_ready), 32'd1);
    next_cyc();
    a1_valid = 1'b0;
    a0_opa = 32'h3F80_0000; a0_opb = 32'h4000_0000; exp0 = 32'h4040_0000; a0_valid = 1'b1;
    next_cyc();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(r1_valid && !r0_valid && r_sum == 32'h3F80_0000 && !a0_ready && !a1_ready && busy))
        bad++;
      next_cyc();
    end
    chk("bp_stable", 32'(bad), 32'd0);
    r1_ready = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("bp_then_a0", 32'(a0_ready), 32'd1);
    next_cyc();
    a0_valid = 1'b0;
    repeat (3) next_cyc();

    // Stray ready from the non-owner while a0 holds its result.
    r0_ready = 1'b0; r1_ready = 1'b0;
    a0_opa = 32'h3F80_0000; a0_opb = 32'h3F80_0000; exp0 = 32'h4000_0000; a0_valid = 1'b1;
    @(negedge clk);
    chk("stray_accept", 32'(a0_ready), 32'd1);
    next_cyc();
    a0_valid = 1'b0;
    next_cyc();
    r1_ready = 1'b1;
    next_cyc();
    r1_ready = 1'b0;
    @(negedge clk);
    chk("stray_hold", {30'd0, r0_valid, busy}, 32'd3);
    chk("stray_sum", r_sum, 32'h4000_0000);
    chk("stray_count", 32'(op_count), 32'(exp_cnt % 16));
    r0_ready = 1'b1; r1_ready = 1'b1;
    repeat (2) next_cyc();

    // Reset while in EXEC discards the operation.
    a0_opa = 32'h3F80_0000; a0_opb = 32'h4000_0000; exp0 = 32'h4040_0000; a0_valid = 1'b1;
    @(negedge clk);
    chk("rm_accept", 32'(a0_ready), 32'd1);
    next_cyc();
    a0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rm_outputs", {27'd0, a0_ready, a1_ready, r0_valid, r1_valid, busy}, 32'd0);
    chk("rm_sum", r_sum, 32'd0);
    next_cyc();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (r0_valid || r1_valid || busy) bad++;
      next_cyc();
    end
    chk("rm_quiet", 32'(bad), 32'd0);
    chk("rm_count", 32'(op_count), 32'd0);
    a0_valid = 1'b1;
    @(negedge clk);
    chk("rm_ready_back", 32'(a0_ready), 32'd1);
    next_cyc();
    a0_valid = 1'b0;
    repeat (4) next_cyc();

    // Arithmetic table, alternating requesters; 17 ops from reset to wrap the 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      do_op(1'(i % 2), tbl[i % 13].a, tbl[i % 13].b, tbl[i % 13].sum);
    end
    @(negedge clk);
    chk("wrap_count", 32'(op_count), 32'd1);
    chk("wrap_model", 32'(op_count), 32'(exp_cnt % 16));
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
